jedro_1_mmio_mailbox: RTL and testbench
=======================================

JEDRO_1_MMIO_MAILBOX -- requirements
Module: jedro_1_mmio_mailbox

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, data-bus address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data-bus word width (only 32 supported).
REQ-003 SHALL have parameter BASE_ADDR, default 32'h8000_0000, 16-byte-aligned base of the register window.
REQ-004 SHALL have parameter FIFO_DEPTH, default 8, console FIFO entries (power of 2, 2..16).
REQ-005 SHALL have one clock and an asynchronous active-low reset, with ports: clk_i in 1 (rising-edge clock); rstn_i in 1 (async active-low reset).
REQ-006 SHALL have port en_i in 1, bus access strobe from the core data-memory master.
REQ-007 SHALL have port we_i in 4, byte write enables; 0 means read.
REQ-008 SHALL have port addr_i in ADDR_WIDTH, byte address.
REQ-009 SHALL have port wdata_i in DATA_WIDTH, write data.
REQ-010 SHALL have port rdata_o out DATA_WIDTH, read data.
REQ-011 SHALL have port done_o out 1, sticky flag for a test-end write.
REQ-012 SHALL have port code_o out 32, latched TOHOST value.
REQ-013 SHALL have port char_valid_o out 1, FIFO head valid.
REQ-014 SHALL have port char_o out 8, FIFO head byte.
REQ-015 SHALL have port char_ready_i in 1, consumer accepts head.

Function
REQ-016 SHALL decode a hit when en_i=1 and addr_i[ADDR_WIDTH-1:4]==BASE_ADDR[ADDR_WIDTH-1:4]; register select is addr_i[3:2]; addr_i[1:0] is ignored.
REQ-017 SHALL map offsets as: 0x0 TOHOST (RW), 0x4 CONSOLE (WO, reads 0), 0x8 CYCLE (RO), 0xC STATUS (RW1C).
REQ-018 SHALL have a read latency of exactly 1 cycle: rdata_o updates on the edge after a hit with we_i=0 and holds until the next read hit.
REQ-019 SHALL drive rdata_o=0 one cycle after a non-hit read (en_i=1, window miss) and ignore non-hit writes.
REQ-020 SHALL latch TOHOST on the first write hit whose byte-enable-masked data is nonzero (disabled lanes taken as 0); the same edge sets done_o=1 and code_o; later TOHOST writes are ignored until reset; a zero write is ignored.
REQ-021 SHALL push wdata_i[7:0] into the FIFO on a CONSOLE write hit with we_i[0]=1; we_i[0]=0 means no push.
REQ-022 SHALL drop a push when the FIFO is full and no pop occurs that cycle, and set sticky overflow.
REQ-023 SHALL assert char_valid_o iff count>0, with char_o as head; a pop occurs on char_valid_o & char_ready_i.
REQ-024 SHALL accept both on a simultaneous push and pop when full; count stays unchanged.
REQ-025 SHALL, on a push when empty, make char_valid_o rise the next cycle; no same-cycle bypass.
REQ-026 SHALL run CYCLE as a 32-bit free-running counter incrementing every clk_i edge after reset, wrapping FFFF_FFFF->0; a read returns the value at the access edge.
REQ-027 SHALL read STATUS as: bit0 empty, bit1 full, bit2 overflow, bits[8:4] count, bit9 done_o, others 0.
REQ-028 SHALL clear overflow on a STATUS write with we_i[0]=1 and wdata_i[2]=1; if an overflowing push occurs the same cycle, set wins.
REQ-029 SHALL let a read hit observe state before the same edge's update, i.e. read-before-write for register state.
REQ-030 SHALL keep FIFO pointers at log2(FIFO_DEPTH) bits with wrap-around, and count at log2(FIFO_DEPTH)+1 bits.

Reset
REQ-031 SHALL, on rstn_i=0 and asynchronously, clear rdata_o, done_o, code_o, the CYCLE counter, FIFO pointers/count and overflow; char_valid_o=0; char_o=0.
REQ-032 SHALL discard FIFO contents on reset assertion mid-operation and restart CYCLE at 0 on the first edge after release.
REQ-033 SHALL ignore bus accesses while rstn_i=0.

Verification
REQ-034 SHALL cover: write 0x1 to BASE+0x0 -> done_o=1, code_o=1 next edge; then write 0x5 -> code_o stays 1.
REQ-035 SHALL cover: with char_ready_i=0, write 'A'..'I' (9 bytes) to BASE+0x4 -> STATUS reads full=1, overflow=1, count=8; drain yields 'A'..'H' in order.
REQ-036 SHALL cover: with FIFO full and char_ready_i=1, push 'Z' in the same cycle -> count stays 8 and 'Z' is the last byte popped; no overflow.
REQ-037 SHALL cover: read BASE+0x8 at cycle N and N+10 -> values differ by 10; force the counter to FFFF_FFFE, then 2 cycles later it reads 0.
REQ-038 SHALL cover: read BASE+0x20 -> rdata_o=0; write to BASE+0x20 -> no state change; write 0x4 to STATUS -> overflow=0.
REQ-039 SHALL cover: assert rstn_i low with 3 bytes queued -> char_valid_o=0 immediately, done_o=0, STATUS empty=1 after release.

Source files
------------

// File: rtl/jedro_1_mmio_mailbox.sv
// rtl/jedro_1_mmio_mailbox.sv - MMIO mailbox: test-end latch, console byte FIFO, cycle counter
module jedro_1_mmio_mailbox #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h8000_0000,
  parameter int unsigned           FIFO_DEPTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  en_i,
  input  logic [3:0]            we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  done_o,
  output logic [31:0]           code_o,
  output logic                  char_valid_o,
  output logic [7:0]            char_o,
  input  logic                  char_ready_i
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

  logic          hit;
  logic          rd_any;
  logic          wr_hit;
  logic [1:0]    sel;
  logic [31:0]   lane_mask;
  logic [31:0]   wdata_masked;
  logic          tohost_wr;
  logic          push_req;
  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  logic          ovf_set;
  logic          ovf_clr;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          overflow;
  logic [31:0]   cycle_q;
  logic [31:0]   status;
  logic [31:0]   rd_val;
  logic [7:0]    mem [FIFO_DEPTH];
  logic          unused_addr_lsb;

  // Byte offset within a word carries no meaning for this register window.
  assign unused_addr_lsb = ^addr_i[1:0];

  // Address decode, write qualification and FIFO handshake terms.
  always_comb begin
    hit          = en_i && (addr_i[ADDR_WIDTH-1:4] == BASE_ADDR[ADDR_WIDTH-1:4]);
    sel          = addr_i[3:2];
    rd_any       = en_i && (we_i == 4'b0000);
    wr_hit       = hit && (we_i != 4'b0000);
    lane_mask    = {{8{we_i[3]}}, {8{we_i[2]}}, {8{we_i[1]}}, {8{we_i[0]}}};
    wdata_masked = wdata_i & lane_mask;
    tohost_wr    = wr_hit && (sel == 2'd0) && !done_o && (wdata_masked != 32'h0);
    empty        = (count == '0);
    full         = (count == FULL_COUNT);
    pop          = !empty && char_ready_i;
    push_req     = wr_hit && (sel == 2'd1) && we_i[0];
    // A full FIFO still takes a byte when the head leaves in the same cycle.
    push         = push_req && (!full || pop);
    ovf_set      = push_req && full && !pop;
    ovf_clr      = wr_hit && (sel == 2'd3) && we_i[0] && wdata_i[2];
    char_valid_o = !empty;
    char_o       = empty ? 8'h00 : mem[rd_ptr];
  end

  // Register readback mux, sampled before this edge's state update.
  always_comb begin
    status = {22'b0, done_o, 5'(count), 1'b0, overflow, full, empty};
    case (sel)
      2'd0:    rd_val = code_o;
      2'd1:    rd_val = 32'h0;
      2'd2:    rd_val = cycle_q;
      default: rd_val = status;
    endcase
  end

  // One-cycle read data; window misses return zero.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rdata_o <= '0;
    end else if (rd_any) begin
      rdata_o <= hit ? rd_val : '0;
    end
  end

  // First nonzero TOHOST write ends the test; later writes are ignored.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      done_o <= 1'b0;
      code_o <= '0;
    end else if (tohost_wr) begin
      done_o <= 1'b1;
      code_o <= wdata_masked;
    end
  end

  // Free-running cycle counter.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cycle_q <= '0;
    end else begin
      cycle_q <= cycle_q + 32'd1;
    end
  end

  // FIFO pointers, occupancy and sticky overflow (set beats clear).
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (ovf_set)      overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

  // FIFO storage; contents are meaningless outside the occupied range.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= wdata_i[7:0];
  end

endmodule

// File: tb/tb_jedro_1_mmio_mailbox.sv
// tb/tb_jedro_1_mmio_mailbox.sv - self-checking bench for jedro_1_mmio_mailbox
module tb_jedro_1_mmio_mailbox;

  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          DEPTH = 8;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        en = 1'b0;
  logic [3:0]  we = 4'h0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        char_ready = 1'b0;
  logic [31:0] rdata;
  logic        done;
  logic [31:0] code;
  logic        char_valid;
  logic [7:0]  char_b;

  int checks = 0;
  int errors = 0;

  logic [7:0]  m_q[$];
  logic        m_done = 1'b0;
  logic        m_ovf = 1'b0;
  logic [31:0] m_code = 32'h0;
  logic [31:0] m_rdata = 32'h0;
  logic [31:0] m_cycle = 32'h0;
  logic [7:0]  popped[$];
  logic [31:0] v1;

  jedro_1_mmio_mailbox #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk_i(clk), .rstn_i(rstn), .en_i(en), .we_i(we), .addr_i(addr),
    .wdata_i(wdata), .rdata_o(rdata), .done_o(done), .code_o(code),
    .char_valid_o(char_valid), .char_o(char_b), .char_ready_i(char_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_status();
    logic [4:0] c;
    c = 5'(m_q.size());
    return {22'b0, m_done, c, 1'b0, m_ovf, (m_q.size() == DEPTH), (m_q.size() == 0)};
  endfunction

  function automatic logic [31:0] m_read(input logic [1:0] sel);
    case (sel)
      2'd0:    return m_code;
      2'd1:    return 32'h0;
      2'd2:    return m_cycle;
      default: return m_status();
    endcase
  endfunction

  // One bus cycle: drive after a falling edge, update the model at the rising edge, check at the next falling edge.
  task automatic step(input logic e, input logic [3:0] w, input logic [31:0] a,
                      input logic [31:0] d, input logic rdy);
    logic        hit;
    logic [1:0]  sel;
    logic [31:0] md;
    logic        pop;
    logic        push_req;
    logic [7:0]  dummy;
    en = e; we = w; addr = a; wdata = d; char_ready = rdy;
    hit = e && (a[31:4] == BASE[31:4]);
    sel = a[3:2];
    md  = d & {{8{w[3]}}, {8{w[2]}}, {8{w[1]}}, {8{w[0]}}};
    if (e && w == 4'h0) m_rdata = hit ? m_read(sel) : 32'h0;
    pop = (m_q.size() != 0) && rdy;
    if (char_valid && rdy) popped.push_back(char_b);
    push_req = hit && (w != 4'h0) && (sel == 2'd1) && w[0];
    @(posedge clk);
    if (hit && w != 4'h0 && sel == 2'd0 && !m_done && md != 32'h0) begin
      m_done = 1'b1;
      m_code = md;
    end
    if (hit && w != 4'h0 && sel == 2'd3 && w[0] && d[2]) m_ovf = 1'b0;
    if (pop) dummy = m_q.pop_front();
    if (push_req) begin
      if (m_q.size() >= DEPTH) m_ovf = 1'b1;
      else m_q.push_back(d[7:0]);
    end
    m_cycle = m_cycle + 32'd1;
    @(negedge clk);
    en = 1'b0; we = 4'h0;
    chk("rdata", rdata, m_rdata);
    chk("done", {31'b0, done}, {31'b0, m_done});
    chk("code", code, m_code);
    chk("char_valid", {31'b0, char_valid}, {31'b0, (m_q.size() != 0)});
    chk("char", {24'b0, char_b}, {24'b0, (m_q.size() != 0) ? m_q[0] : 8'h00});
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w = 4'hF,
                    input logic rdy = 1'b0);
    step(1'b1, w, a, d, rdy);
  endtask

  task automatic rd(input logic [31:0] a, input logic rdy = 1'b0);
    step(1'b1, 4'h0, a, 32'h0, rdy);
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 4'h0, 32'h0, 32'h0, rdy);
  endtask

  // Assert reset with a bus write pending; outputs must clear at once.
  task automatic do_reset();
    rstn = 1'b0; en = 1'b1; we = 4'hF; addr = BASE; wdata = 32'h55;
    #1;
    chk("rst_char_valid", {31'b0, char_valid}, 32'h0);
    chk("rst_char", {24'b0, char_b}, 32'h0);
    chk("rst_done", {31'b0, done}, 32'h0);
    chk("rst_code", code, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    m_q.delete(); m_done = 1'b0; m_ovf = 1'b0; m_code = 32'h0; m_rdata = 32'h0; m_cycle = 32'h0;
    repeat (2) @(negedge clk);
    en = 1'b0; we = 4'h0;
    rstn = 1'b1;
  endtask

  initial begin
    logic [31:0] a;
    logic [3:0]  w;
    int          r;
    do_reset();

    // Test-end latch: zero and lane-masked-zero writes are ignored.
    wr(BASE, 32'h0);
    wr(BASE, 32'h100, 4'b0001);
    chk("tohost_zero_ignored", {31'b0, done}, 32'h0);
    wr(BASE, 32'h1);
    chk("tohost_done", {31'b0, done}, 32'h1);
    chk("tohost_code", code, 32'h1);
    wr(BASE, 32'h5);
    chk("tohost_sticky", code, 32'h1);
    rd(BASE);
    chk("tohost_read", rdata, 32'h1);

    // Overflow: nine bytes into eight slots, then drain in order.
    for (int i = 0; i < 9; i++) wr(BASE + 32'h4, 32'h41 + i);
    rd(BASE + 32'hC);
    chk("status_full_ovf", rdata, 32'h286);
    popped.delete();
    repeat (8) idle(1'b1);
    chk("drain_count", popped.size(), 32'd8);
    for (int i = 0; i < 8 && i < popped.size(); i++) chk("drain_order", {24'b0, popped[i]}, 32'h41 + i);
    idle(1'b1);
    wr(BASE + 32'hC, 32'h4, 4'b0001);
    rd(BASE + 32'hC);
    chk("status_ovf_cleared", rdata, 32'h201);

    // Full FIFO with simultaneous pop and push.
    for (int i = 0; i < 8; i++) wr(BASE + 32'h4, 32'h61 + i);
    wr(BASE + 32'h4, 32'h5A, 4'hF, 1'b1);
    rd(BASE + 32'hC);
    chk("status_push_pop_full", rdata, 32'h282);
    popped.delete();
    repeat (8) idle(1'b1);
    chk("pp_drain_count", popped.size(), 32'd8);
    if (popped.size() == 8) begin
      chk("pp_first", {24'b0, popped[0]}, 32'h62);
      chk("pp_last_z", {24'b0, popped[7]}, 32'h5A);
    end

    // Cycle counter spacing and wrap.
    rd(BASE + 32'h8);
    v1 = rdata;
    repeat (9) idle(1'b0);
    rd(BASE + 32'h8);
    chk("cycle_delta", rdata - v1, 32'd10);
    force dut.cycle_q = 32'hFFFF_FFFE;
    #1;
    release dut.cycle_q;
    m_cycle = 32'hFFFF_FFFE;
    rd(BASE + 32'h8);
    chk("cycle_fffe", rdata, 32'hFFFF_FFFE);
    rd(BASE + 32'h8);
    rd(BASE + 32'h8);
    chk("cycle_wrap", rdata, 32'h0);

    // Window misses and overflow clear.
    rd(BASE);
    rd(BASE + 32'h20);
    chk("miss_read_zero", rdata, 32'h0);
    wr(BASE + 32'h24, 32'h41);
    wr(BASE + 32'h20, 32'h7);
    rd(BASE + 32'hC);
    chk("miss_write_ignored", rdata, 32'h201);
    for (int i = 0; i < 9; i++) wr(BASE + 32'h4, 32'h30 + i);
    wr(BASE + 32'hC, 32'h4, 4'b0001);
    rd(BASE + 32'hC);
    chk("ovf_clear_full", rdata, 32'h282);
    repeat (8) idle(1'b1);

    // Randomized traffic against the reference model.
    do_reset();
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 9);
      if (r < 7)       a = BASE | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
      else if (r < 9)  a = BASE + 32'h20 + 32'($urandom_range(0, 63));
      else             a = $urandom;
      w = ($urandom_range(0, 9) < 4) ? 4'h0 : 4'($urandom_range(0, 15));
      step($urandom_range(0, 4) != 0, w, a, $urandom, $urandom_range(0, 2) == 0);
    end

    // Reset with bytes queued discards them.
    repeat (10) idle(1'b1);
    for (int i = 0; i < 3; i++) wr(BASE + 32'h4, 32'h71 + i);
    chk("queued_valid", {31'b0, char_valid}, 32'h1);
    do_reset();
    rd(BASE + 32'hC);
    chk("post_reset_status", rdata, 32'h001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
